// File: rtl/word_tokenizer_pkg.sv
// word_tokenizer_pkg: character constants, delimiter classifier and tokenizer state type
package forth_pkg;
    localparam int DATA_WIDTH = 8;
    localparam logic [DATA_WIDTH-1:0] CH_SPACE = 8'h20;
    localparam logic [DATA_WIDTH-1:0] CH_TAB = 8'h09;
    localparam logic [DATA_WIDTH-1:0] CH_LF = 8'h0A;
    localparam logic [DATA_WIDTH-1:0] CH_CR = 8'h0D;
    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, EMIT} tok_state_t;
    function automatic logic is_delim(input logic [DATA_WIDTH-1:0] c);
        return c == CH_SPACE || c == CH_TAB || c == CH_LF || c == CH_CR;
    endfunction
endpackage

// File: rtl/word_tokenizer_if.sv
// word_tokenizer_if: character stream in, assembled word out; slave is the tokenizer side
interface word_tokenizer_if #(parameter int WIDTH = 32);
    logic [forth_pkg::DATA_WIDTH-1:0] ch;
    logic ch_valid;
    logic ch_ready;
    logic [forth_pkg::DATA_WIDTH-1:0] word [WIDTH];
    logic [$clog2(WIDTH)-1:0] len;
    logic word_valid;
    logic word_ready;
    logic trunc;
    logic eol;
    modport slave (input ch, ch_valid, word_ready, output ch_ready, word, len, word_valid, trunc, eol);
    modport master (output ch, ch_valid, word_ready, input ch_ready, word, len, word_valid, trunc, eol);
endinterface

// File: rtl/word_tokenizer.sv
// word_tokenizer: splits a character stream into whitespace-delimited words.
// Define WORD_TOKENIZER_UPCASE_EN to fold 'a'..'z' to upper case when stored.
module word_tokenizer import forth_pkg::*; #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst_n,
    word_tokenizer_if.slave bus
);
    localparam int LW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_COLLECT = COLLECT;
    localparam logic [1:0] S_DISCARD = DISCARD;
    localparam logic [1:0] S_EMIT = EMIT;

    logic [1:0] state;
    logic acc, delim, eol_ch;
    logic [DATA_WIDTH-1:0] ch_in;

    assign acc = bus.ch_valid && bus.ch_ready;
    assign delim = is_delim(bus.ch);
    assign eol_ch = bus.ch == CH_LF || bus.ch == CH_CR;
`ifdef WORD_TOKENIZER_UPCASE_EN
    assign ch_in = (bus.ch >= "a" && bus.ch <= "z") ? bus.ch - 8'h20 : bus.ch;
`else
    assign ch_in = bus.ch;
`endif
    assign bus.ch_ready = state != S_EMIT;
    assign bus.word_valid = state == S_EMIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            for (int i = 0; i < WIDTH; i++) bus.word[i] <= '0;
            bus.len <= '0;
            bus.trunc <= 1'b0;
            bus.eol <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (acc && !delim) begin
                    bus.word[0] <= ch_in;
                    bus.len <= LW'(1);
                    state <= S_COLLECT;
                end
                S_COLLECT, S_DISCARD: if (acc) begin
                    if (delim) begin
                        state <= S_EMIT;
                        bus.eol <= eol_ch;
                    end else if (state == S_COLLECT && bus.len < LW'(WIDTH - 1)) begin
                        bus.word[bus.len] <= ch_in;
                        bus.len <= bus.len + 1'b1;
                    end else begin
                        bus.trunc <= 1'b1;
                        state <= S_DISCARD;
                    end
                end
                default: if (bus.word_ready) begin
                    // buffer is cleared on handoff so unused entries always read zero
                    for (int i = 0; i < WIDTH; i++) bus.word[i] <= '0;
                    bus.len <= '0;
                    bus.trunc <= 1'b0;
                    bus.eol <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_word_tokenizer.sv
// tb_word_tokenizer: directed and random character streams checked against a word-splitting model
module tb_word_tokenizer;
    import forth_pkg::*;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0][7:0] c;
        logic [4:0] len;
        logic trunc;
        logic eol;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    word_tokenizer_if #(.WIDTH(W)) bus ();
    word_tokenizer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pk();
        logic [255:0] r;
        for (int k = 0; k < W; k++) r[k*8 +: 8] = bus.word[k];
        return r;
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef WORD_TOKENIZER_UPCASE_EN
        return (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
`else
        return c;
`endif
    endfunction

    // Reference: every maximal run of non-delimiters ended by a delimiter is one word
    function automatic void model(input string s);
        exp_t cur = '0;
        bit in_w = 0;
        for (int i = 0; i < s.len(); i++) begin
            byte ch = s[i];
            if (ch inside {8'd32, 8'd9, 8'd10, 8'd13}) begin
                if (in_w) begin
                    cur.eol = (ch == 8'd10 || ch == 8'd13);
                    q.push_back(cur);
                end
                cur = '0;
                in_w = 0;
            end else if (!in_w) begin
                cur.c[0] = fold(ch);
                cur.len = 1;
                in_w = 1;
            end else if (int'(cur.len) < W - 1) begin
                cur.c[cur.len] = fold(ch);
                cur.len = cur.len + 5'd1;
            end else cur.trunc = 1;
        end
    endfunction

    task automatic run(input string s, input int vp, input int rp);
        int idx = 0;
        int cyc = 0;
        bit held = 0;
        logic [255:0] snap = '0;
        exp_t e;
        model(s);
        while ((idx < s.len() || q.size() > 0 || bus.word_valid) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            chk("ready_vs_valid", bus.ch_ready, !bus.word_valid);
            if (bus.word_valid) chk("len_nonzero", bus.len != 0, 1);
            if (held && bus.word_valid) chk("word_stable", pk(), snap);
            bus.word_ready = $urandom_range(99) < rp;
            bus.ch_valid = idx < s.len() && $urandom_range(99) < vp;
            bus.ch = bus.ch_valid ? s[idx] : 8'($urandom);
            if (bus.word_valid && bus.word_ready) begin
                if (q.size() == 0) chk("unexpected_word", pk(), 0);
                else begin
                    e = q.pop_front();
                    chk("word", pk(), e.c);
                    chk("len", bus.len, e.len);
                    chk("trunc", bus.trunc, e.trunc);
                    chk("eol", bus.eol, e.eol);
                end
                held = 0;
            end else begin
                held = bus.word_valid;
                snap = pk();
            end
            if (bus.ch_valid && bus.ch_ready) idx++;
        end
        @(posedge clk);
        #1;
        bus.ch_valid = 1'b0;
        bus.word_ready = 1'b0;
        chk("stream_consumed", idx, s.len());
        chk("words_drained", q.size(), 0);
        q.delete();
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        chk("send_ready", bus.ch_ready, 1);
        bus.ch = c;
        bus.ch_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.ch_valid = 1'b0;
    endtask

    initial begin
        string s;
        logic [255:0] exp_w;
        bus.ch = '0;
        bus.ch_valid = 1'b0;
        bus.word_ready = 1'b0;
        #1;
        chk("rst_valid", bus.word_valid, 0);
        chk("rst_len", bus.len, 0);
        chk("rst_word", pk(), 0);
        chk("rst_trunc_eol", {bus.trunc, bus.eol}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", bus.ch_ready, 1);

        run("12 34\n", 100, 100);
        run("   \015\n\t  ", 100, 100);
        run("12 34\n", 60, 40);

        bus.word_ready = 1'b0;
        send("D"); send("U"); send("P"); send(" ");
        exp_w = '0;
        exp_w[23:0] = {8'h50, 8'h55, 8'h44};
        bus.ch = "X";
        bus.ch_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.word_valid, 1);
            chk("hold_ready", bus.ch_ready, 0);
            chk("hold_word", pk(), exp_w);
            chk("hold_len", bus.len, 3);
        end
        bus.word_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_valid", bus.word_valid, 0);
        chk("post_hs_cleared", {pk(), bus.len}, 0);
        chk("post_hs_ready", bus.ch_ready, 1);
        @(posedge clk);
        #1;
        bus.ch_valid = 1'b0;
        bus.word_ready = 1'b0;
        send(" ");
        @(negedge clk);
        chk("x_word", pk(), 256'h58);
        chk("x_len", bus.len, 1);
        bus.word_ready = 1'b1;
        @(negedge clk);
        chk("x_done", bus.word_valid, 0);
        bus.word_ready = 1'b0;

        s = "";
        for (int i = 0; i < 40; i++) s = {s, "A"};
        run({s, " B "}, 100, 100);
        run({s, s, "\n"}, 70, 50);

        run("AB", 100, 100);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midword_rst_len", bus.len, 0);
        chk("midword_rst_word", pk(), 0);
        chk("midword_rst_valid", bus.word_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run("7 ", 100, 100);

        run("dup 3 ", 100, 100);

        for (int it = 0; it < 25; it++) begin
            int n = $urandom_range(60, 5);
            s = "";
            for (int i = 0; i < n; i++) begin
                int r = $urandom_range(99);
                logic [7:0] b;
                if (r < 25) b = (r < 15) ? 8'h20 : (r < 19) ? 8'h09 : (r < 22) ? 8'h0a : 8'h0d;
                else if (r < 40) b = 8'($urandom_range(8'h7a, 8'h61));
                else if (r < 45) b = 8'($urandom_range(8'h08, 8'h01));
                else b = 8'($urandom_range(8'h7e, 8'h21));
                s = {s, $sformatf("%c", b)};
                if (it % 5 == 0 && i == 2) for (int k = 0; k < 35; k++) s = {s, "z"};
            end
            s = {s, (it % 2) ? "\n" : " "};
            run(s, $urandom_range(100, 30), $urandom_range(100, 20));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
